// File: rtl/freq_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : freq_channel_scheduler
// Description : Round-robin time-multiplexer that lends a single frequency
//               counter to CHANNELS input signals. Each selected channel gets
//               a one-cycle LOAD (period load + counter restart) followed by a
//               dwell of period + DWELL_MARGIN + 1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_channel_scheduler #(
    parameter int CHANNELS     = 4,
    parameter int BITS         = 12,
    parameter int DWELL_MARGIN = 16,
    parameter int MIN_PERIOD   = 16,
    parameter int RESET_PERIOD = 1200
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [CHANNELS-1:0]         chan_signal,
    input  logic [CHANNELS-1:0]         chan_enable,
    input  logic                        cfg_we,
    input  logic [$clog2(CHANNELS)-1:0] cfg_addr,
    input  logic [BITS-1:0]             cfg_period,
    output logic                        meas_signal,
    output logic [BITS-1:0]             meas_period,
    output logic                        meas_period_load,
    output logic                        counter_rst,
    output logic [$clog2(CHANNELS)-1:0] active_chan,
    output logic                        active_valid,
    output logic                        window_done
);

    localparam int              c_AW      = $clog2(CHANNELS);
    localparam logic [BITS:0]   c_MARGIN  = DWELL_MARGIN[BITS:0];
    localparam logic [BITS-1:0] c_MIN_PER = MIN_PERIOD[BITS-1:0];
    localparam logic [BITS-1:0] c_RST_PER = RESET_PERIOD[BITS-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    state_t              r_state;
    logic [BITS-1:0]     r_period [CHANNELS];
    logic [c_AW-1:0]     r_rr;
    logic [c_AW-1:0]     r_active;
    logic                r_valid;
    logic [BITS-1:0]     r_meas_period;
    logic                r_load;
    logic                r_crst;
    logic [BITS:0]       r_cnt;
    logic                r_drop;

    logic                w_addr_ok;
    logic [BITS-1:0]     w_clamped;
    logic [c_AW-1:0]     w_act_inc;
    logic [c_AW-1:0]     w_start;
    logic [c_AW-1:0]     w_next;
    logic                w_found;
    logic [BITS:0]       w_end;
    logic                w_leave;
    logic                w_launch;

    // Write address decode and period clamp for the configuration port.
    always_comb begin
        w_addr_ok = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_addr == i[c_AW-1:0]) begin
                w_addr_ok = 1'b1;
            end
        end
        w_clamped = (cfg_period < c_MIN_PER) ? c_MIN_PER : cfg_period;
    end

    // Round-robin search: first enabled channel at or after the start pointer.
    always_comb begin
        w_act_inc = (int'(r_active) == CHANNELS - 1) ? '0 : r_active + c_AW'(1);
        w_start   = (r_state == S_DWELL) ? w_act_inc : r_rr;
        w_found   = 1'b0;
        w_next    = '0;
        // Walk offsets from farthest to nearest so the nearest match wins.
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if ((((int'(w_start) + k) % CHANNELS) == c) && chan_enable[c]) begin
                    w_found = 1'b1;
                    w_next  = c[c_AW-1:0];
                end
            end
        end
    end

    // Dwell termination: abort (pending drop) takes priority over completion.
    always_comb begin
        w_end       = {1'b0, r_meas_period} + c_MARGIN;
        w_leave     = (r_state == S_DWELL) && (r_drop || (r_cnt == w_end));
        window_done = (r_state == S_DWELL) && (r_cnt == w_end) && !r_drop;
        w_launch    = w_found && ((r_state == S_IDLE) || w_leave);
        meas_signal = (r_state == S_DWELL) ? chan_signal[r_active] : 1'b0;
    end

    // Per-channel period registers; a write never disturbs the latched copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_period[i] <= c_RST_PER;
            end
        end else if (cfg_we && w_addr_ok) begin
            r_period[cfg_addr] <= w_clamped;
        end
    end

    // Scheduler FSM with registered counter-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_rr          <= '0;
            r_active      <= '0;
            r_valid       <= 1'b0;
            r_meas_period <= c_RST_PER;
            r_load        <= 1'b0;
            r_crst        <= 1'b0;
            r_cnt         <= '0;
            r_drop        <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_crst <= 1'b0;
            case (r_state)
                S_IDLE: begin
                end
                S_LOAD: begin
                    r_state <= S_DWELL;
                    r_cnt   <= '0;
                end
                S_DWELL: begin
                    if (w_leave) begin
                        r_rr     <= w_act_inc;
                        r_drop   <= 1'b0;
                        r_state  <= S_IDLE;
                        r_valid  <= 1'b0;
                        r_active <= '0;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_drop <= !chan_enable[r_active];
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_valid  <= 1'b0;
                    r_active <= '0;
                    r_drop   <= 1'b0;
                end
            endcase
            // Selecting a channel overrides the idle fall-back above.
            if (w_launch) begin
                r_state       <= S_LOAD;
                r_active      <= w_next;
                r_meas_period <= r_period[w_next];
                r_load        <= 1'b1;
                r_crst        <= 1'b1;
                r_valid       <= 1'b1;
                r_cnt         <= '0;
                r_drop        <= 1'b0;
            end
        end
    end

    assign meas_period      = r_meas_period;
    assign meas_period_load = r_load;
    assign counter_rst      = r_crst;
    assign active_chan      = r_active;
    assign active_valid     = r_valid;

endmodule
`default_nettype wire

// File: doc/freq_channel_scheduler.md
Name: freq_channel_scheduler

Overview:
Time-multiplexes one frequency_counter core across CHANNELS input signals.
- Selects the next enabled channel in round-robin order.
- Loads that channel's gate period into the counter and restarts the counter's window with a one-cycle reset.
- Holds the channel for the full count-plus-decode time, then advances.
- Sits between the pad-level signal inputs and the counter's signal/period/period_load/reset inputs.

Parameters:
CHANNELS, 4, number of multiplexed input signals (2..8).
BITS, 12, width of gate period; matches the counter's period port.
DWELL_MARGIN, 16, extra clocks held after the gate period so the counter's tens/units decode completes.
MIN_PERIOD, 16, smallest programmable period; smaller writes are clamped up to this.
RESET_PERIOD, 1200, per-channel period after reset.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
chan_signal  input  CHANNELS  raw asynchronous signals to measure
chan_enable  input  CHANNELS  per-channel scan enable, synchronous level
cfg_we  input  1  write strobe for a period register
cfg_addr  input  clog2(CHANNELS)  channel index for the write
cfg_period  input  BITS  period value for the write
meas_signal  output  1  selected channel signal, to counter signal
meas_period  output  BITS  period latched for the current channel, to counter period
meas_period_load  output  1  one-cycle load strobe, to counter period_load
counter_rst  output  1  one-cycle active-high restart, to counter reset
active_chan  output  clog2(CHANNELS)  channel currently owning the counter
active_valid  output  1  high while a channel owns the counter
window_done  output  1  one-cycle pulse when the current channel's dwell completes normally

Behaviour:
- Reset (async assert, sync release):
  - every period_reg = RESET_PERIOD; state IDLE; rr pointer 0.
  - active_chan 0, active_valid 0, meas_signal 0, meas_period RESET_PERIOD, meas_period_load 0, counter_rst 0, window_done 0.
- Config writes:
  - cfg_we writes period_reg[cfg_addr] = max(cfg_period, MIN_PERIOD).
  - cfg_addr >= CHANNELS is ignored.
  - Writes are accepted in any state.
  - A write to the active channel takes effect at that channel's next LOAD. The current dwell uses the value latched at LOAD.
- Next-channel search (NEXT): first enabled channel at or after the rr pointer, wrapping; none enabled -> IDLE.
- FSM:
  - IDLE: outputs idle as at reset, except meas_period keeps its last value. When chan_enable != 0, run NEXT; go to LOAD on the following cycle.
  - LOAD, exactly 1 cycle:
    - active_chan = selected channel; meas_period = period_reg[active_chan] (latched); meas_period_load = 1; counter_rst = 1; active_valid = 1.
    - dwell_cnt = 0 (BITS+1 bits, no overflow at max period + margin).
    - Next state DWELL.
  - DWELL:
    - meas_signal = chan_signal[active_chan], combinational mux from registered select; the counter synchronises it.
    - dwell_cnt increments each cycle.
    - When dwell_cnt == meas_period + DWELL_MARGIN: pulse window_done; rr pointer = active_chan+1 mod CHANNELS; run NEXT; go to LOAD, or to IDLE if nothing is enabled.
    - Dwell length is therefore meas_period + DWELL_MARGIN + 1 cycles, and LOAD-to-LOAD spacing is meas_period + DWELL_MARGIN + 2.
- Disable mid-dwell: if chan_enable[active_chan] drops during DWELL, abort on the next cycle with no window_done. rr pointer = active_chan+1, then NEXT as above.
- Simultaneous events:
  - Abort wins over normal dwell completion in the same cycle.
  - A cfg write and LOAD of the same channel in the same cycle: LOAD latches the old value.
- Single enabled channel: re-selected every dwell, with LOAD and counter_rst repeated each time.
- meas_signal is 0 in IDLE and LOAD.
- Any other state encoding returns to IDLE.

Test Plan:
- Reset, then enable=4'b0101 with periods at default -> LOAD on ch0 with meas_period=1200, one-cycle load/rst pulses; window_done 1217 cycles after LOAD; LOAD ch2 next cycle; then ch0 again.
- Write ch1 period=5 -> stored as 16; enable=4'b0010 -> LOAD-to-LOAD spacing is 34 cycles, meas_period=16.
- During a ch0 dwell, write ch0 period=100 -> current dwell still 1217 cycles; next ch0 LOAD drives meas_period=100.
- enable=4'b1111, drop bit 1 mid-dwell of ch1 -> no window_done; LOAD ch2 two cycles after the drop.
- enable drops to 0 mid-dwell -> IDLE, active_valid=0, meas_signal=0; re-enable bit3 -> LOAD ch3.
- Assert reset_n low mid-dwell, asynchronously, between clock edges -> all outputs take reset values immediately; periods return to 1200.
